// File: rtl/pfb_pkg.sv
// Shared types for the pixel frame buffer: FSM state encoding and controller
// command opcodes.
package pfb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10,
    ST_CLEAR = 2'b11
  } pfb_state_e;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  function automatic int pfb_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pfb_mem.sv
// Single-port frame store: synchronous write, registered read with enable.
// The read register doubles as the block's output data register.
module pfb_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 12,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/pixel_frame_buffer.sv
// Pixel frame buffer: WRITE/READ/CLEAR command FSM over a DEPTH-sample store.
// Optional `PFB_LEVEL_EN adds a level output counting samples of the last WRITE.
module pixel_frame_buffer
  import pfb_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int IMG_H    = 2,
  parameter  int IMG_W    = 2,
  parameter  int CHANNELS = 3,
  localparam int DEPTH    = IMG_H * IMG_W * CHANNELS,
  localparam int ADDR_W   = pfb_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
`ifdef PFB_LEVEL_EN
  output logic [ADDR_W:0]   level,
`endif
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  pfb_state_e        state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt, addr_inc, mem_addr;
  logic              ov_nxt, done_nxt;
  logic              we, re;
  logic [DATA_W-1:0] wdata, rdata;

  assign addr_inc  = addr + 1'b1;
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign in_ready  = (state == ST_WRITE);
  assign out_data  = out_valid ? rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      out_valid <= ov_nxt;
      done      <= done_nxt;
    end
  end

  // In READ, addr tracks the sample held in the output register, so the next
  // fetch targets addr+1. Sample 0 is prefetched on command acceptance so the
  // first beat is valid one cycle later.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    ov_nxt    = out_valid;
    done_nxt  = 1'b0;
    we        = 1'b0;
    re        = 1'b0;
    mem_addr  = addr;
    wdata     = in_data;
    case (state)
      ST_IDLE: begin
        mem_addr = '0;
        if (cmd_valid) begin
          case (cmd_op)
            CMD_WRITE: begin
              state_nxt = ST_WRITE;
              addr_nxt  = '0;
            end
            CMD_READ: begin
              state_nxt = ST_READ;
              addr_nxt  = '0;
              re        = 1'b1;
              ov_nxt    = 1'b1;
            end
            CMD_CLEAR: begin
              state_nxt = ST_CLEAR;
              addr_nxt  = '0;
            end
            default: ;
          endcase
        end
      end
      ST_WRITE: begin
        if (in_valid) begin
          we = 1'b1;
          if (addr == LAST) begin
            state_nxt = ST_IDLE;
            addr_nxt  = '0;
            done_nxt  = 1'b1;
          end else begin
            addr_nxt = addr_inc;
          end
        end
      end
      ST_READ: begin
        if (addr == LAST) begin
          if (out_valid && out_ready) begin
            state_nxt = ST_IDLE;
            addr_nxt  = '0;
            ov_nxt    = 1'b0;
            done_nxt  = 1'b1;
          end
        end else if (!out_valid || out_ready) begin
          re       = 1'b1;
          mem_addr = addr_inc;
          addr_nxt = addr_inc;
          ov_nxt   = 1'b1;
        end
      end
      ST_CLEAR: begin
        we    = 1'b1;
        wdata = '0;
        if (addr == LAST) begin
          state_nxt = ST_IDLE;
          addr_nxt  = '0;
          done_nxt  = 1'b1;
        end else begin
          addr_nxt = addr_inc;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        addr_nxt  = '0;
        ov_nxt    = 1'b0;
      end
    endcase
  end

  pfb_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .re   (re),
    .addr (mem_addr),
    .wdata(wdata),
    .rdata(rdata)
  );

`ifdef PFB_LEVEL_EN
  logic [ADDR_W:0] level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      level_q <= '0;
    else if (state == ST_IDLE && cmd_valid && (cmd_op == CMD_WRITE || cmd_op == CMD_CLEAR))
      level_q <= '0;
    else if (state == ST_WRITE && in_valid)
      level_q <= level_q + 1'b1;
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Randomized self-checking bench for pixel_frame_buffer against a simple
// array model of the frame store.
module tb_pixel_frame_buffer;
  import pfb_pkg::*;

  localparam int DATA_W = 8;
  localparam int IMG_H = 2;
  localparam int IMG_W = 2;
  localparam int CHANNELS = 3;
  localparam int DEPTH = IMG_H * IMG_W * CHANNELS;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic cmd_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic busy;
  logic done;
`ifdef PFB_LEVEL_EN
  logic [ADDR_W:0] level;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [DATA_W-1:0] model [DEPTH];

  always #5 clk = ~clk;

  pixel_frame_buffer #(
    .DATA_W(DATA_W), .IMG_H(IMG_H), .IMG_W(IMG_W), .CHANNELS(CHANNELS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy),
`ifdef PFB_LEVEL_EN
    .level(level),
`endif
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_state(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  task automatic issue(input logic [1:0] op);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = CMD_NONE;
  endtask

  // rnd=0: back-to-back samples base+i; rnd=1: random data and in_valid gaps
  task automatic wr(input bit rnd, input int base);
    int n = 0, rdy = 0, cyc = 0;
    bit seen = 0;
    issue(CMD_WRITE);
    chk("wr_busy", busy, 1);
    while (cyc < 200) begin
      if (done) begin seen = 1; break; end
`ifdef PFB_LEVEL_EN
      chk("wr_level", level, n);
`endif
      if (in_ready) rdy++;
      in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data = rnd ? DATA_W'($urandom) : DATA_W'(base + n);
      if (in_valid && in_ready) begin
        if (n < DEPTH) model[n] = in_data;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("wr_done_seen", seen, 1);
    chk("wr_beats", n, DEPTH);
    if (!rnd) chk("wr_ready_cycles", rdy, DEPTH);
    idle_state("wr_end");
    @(negedge clk);
    chk("wr_done_pulse", done, 0);
`ifdef PFB_LEVEL_EN
    chk("wr_level_hold", level, DEPTH);
`endif
  endtask

  // mode 0: out_ready high; 1: random; 2: 2-cycle stalls on beats 3 and 7
  task automatic rd(input int mode);
    int n = 0, cyc = 0, nstall = 0, hold = 0;
    bit seen = 0;
    issue(CMD_READ);
    chk("rd_first_valid", out_valid, 1);
    while (cyc < 200) begin
      if (done) begin seen = 1; break; end
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = ($urandom_range(0, 2) != 0);
      else if ((n == 3 || n == 7) && hold < 2) begin out_ready = 1'b0; hold++; end
      else out_ready = 1'b1;
      if (out_valid && !out_ready) begin
        nstall++;
        if (n < DEPTH) chk("rd_hold", out_data, model[n]);
      end
      if (out_valid && out_ready) begin
        if (n < DEPTH) chk("rd_beat", out_data, model[n]);
        n++;
        hold = 0;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("rd_done_seen", seen, 1);
    chk("rd_beats", n, DEPTH);
    chk("rd_cycles", cyc, DEPTH + nstall);
    if (mode == 2) chk("rd_stall_cycles", cyc, DEPTH + 4);
    idle_state("rd_end");
  endtask

  task automatic clr();
    int cyc = 0;
    bit seen = 0;
    issue(CMD_CLEAR);
    while (cyc < 200) begin
      if (done) begin seen = 1; break; end
      if (cyc >= 1 && cyc <= 3) begin
        chk("clr_cmd_ready", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_op = CMD_WRITE;
      end else begin
        cmd_valid = 1'b0;
        cmd_op = CMD_NONE;
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    chk("clr_done_seen", seen, 1);
    chk("clr_cycles", cyc, DEPTH);
    @(negedge clk);
    idle_state("clr_no_queue");
`ifdef PFB_LEVEL_EN
    chk("clr_level", level, 0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    idle_state("reset");
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    idle_state("post_reset");

    wr(0, 'h10);
    rd(0);
    rd(2);
    clr();
    rd(0);

    // op 00 must leave the FSM idle
    issue(CMD_NONE);
    idle_state("op_none");

    for (int k = 0; k < 3; k++) begin
      wr(1, 0);
      rd(1);
    end

    // reset in the middle of a write, then restart from address 0
    begin
      int n = 0;
      issue(CMD_WRITE);
      while (n < 5) begin
        in_valid = 1'b1;
        in_data = DATA_W'('h60 + n);
        if (in_ready) begin model[n] = in_data; n++; end
        @(negedge clk);
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      idle_state("mid_reset");
      chk("mid_reset_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      idle_state("mid_reset_rel");
    end
    wr(0, 'h40);
    rd(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_frame_buffer.md
PIXEL_FRAME_BUFFER -- requirements
Module: pixel_frame_buffer

Interface
REQ-001 Parameter DATA_W, default 8: bits per channel sample.
REQ-002 Parameter IMG_H, default 2: image height in pixels.
REQ-003 Parameter IMG_W, default 2: image width in pixels.
REQ-004 Parameter CHANNELS, default 3: samples per pixel (3 = RGB, 1 = gray).
REQ-005 Derived constants SHALL be DEPTH = IMG_H*IMG_W*CHANNELS and ADDR_W = clog2(DEPTH), minimum 1.
REQ-006 clk  input  1  clock; all logic on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 cmd_valid  input  1  command strobe from the controller.
REQ-009 cmd_op  input  2  command: 01 = WRITE, 10 = READ, 11 = CLEAR, 00 = ignored.
REQ-010 cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
REQ-011 in_data  input  DATA_W  camera sample.
REQ-012 in_valid  input  1  in_data valid.
REQ-013 in_ready  output  1  high only in WRITE.
REQ-014 out_data  output  DATA_W  sample to the grayscaler.
REQ-015 out_valid  output  1  out_data valid.
REQ-016 out_ready  input  1  downstream accepts out_data; replaces the old pause.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done  output  1  one-cycle pulse on operation completion.

Function
REQ-019 FSM states SHALL be IDLE, WRITE, READ, CLEAR; unused encodings SHALL return to IDLE.
REQ-020 IDLE: an accepted command SHALL zero the address pointer and enter WRITE, READ or CLEAR; op 00 SHALL leave the FSM in IDLE.
REQ-021 WRITE: on each in_valid && in_ready cycle, mem[addr] <= in_data and addr increments; after the beat at addr = DEPTH-1, the FSM SHALL enter IDLE and pulse done in the following cycle.
REQ-022 READ: out_data/out_valid SHALL come from an output register loaded with mem[addr] whenever (!out_valid || out_ready) and unread samples remain; first out_valid SHALL appear 1 cycle after command acceptance.
REQ-023 Backpressure: while out_valid && !out_ready, out_data and out_valid SHALL hold and addr SHALL not advance; no sample may be dropped or duplicated.
REQ-024 With out_ready held high, READ SHALL deliver one sample per cycle (DEPTH beats in DEPTH consecutive cycles).
REQ-025 READ SHALL end when beat DEPTH-1 is accepted: next cycle FSM = IDLE, out_valid = 0, done = 1.
REQ-026 CLEAR: mem[addr] <= 0 every cycle for DEPTH cycles, then IDLE with a done pulse; no handshake involved.
REQ-027 Address wrap: addr SHALL never exceed DEPTH-1 and SHALL be zeroed on command acceptance; it SHALL not wrap mid-operation.
REQ-028 out_data SHALL be 0 when out_valid = 0; the output SHALL never be tri-stated.
REQ-029 cmd_valid while busy SHALL be ignored with no effect, and the command SHALL not be queued.

Reset
REQ-030 Reset assertion at any time, including mid-operation, SHALL force IDLE, addr = 0, out_valid = 0, out_data = 0, done = 0, busy = 0, in_ready = 0, cmd_ready = 1 after release.
REQ-031 Memory contents SHALL not be reset; only CLEAR zeroes them.

Configuration
REQ-032 With macro PFB_LEVEL_EN defined, the block SHALL add output level [ADDR_W:0]: samples written in the current or last WRITE, zeroed by CLEAR and reset, held otherwise.
REQ-033 With PFB_LEVEL_EN undefined, the level port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-034 Package pfb_pkg SHALL hold the state enum typedef and the cmd_op encodings (CMD_NONE, CMD_WRITE, CMD_READ, CMD_CLEAR).
REQ-035 The storage array SHALL be a sub-module pfb_mem: single-port, synchronous write, registered read, DEPTH x DATA_W.

Verification
REQ-036 Defaults; WRITE with 12 samples 0x10..0x1B, in_valid always high -> 12 in_ready cycles, done pulse, FSM = IDLE.
REQ-037 READ with out_ready high -> out_data 0x10..0x1B on 12 consecutive cycles, then done, out_valid = 0.
REQ-038 READ with out_ready low on beats 3 and 7 for 2 cycles each -> out_data held (0x13, 0x17); full sequence intact, done after 16 cycles.
REQ-039 CLEAR, then READ -> 12 beats of 0x00; cmd_valid during CLEAR is ignored (cmd_ready = 0).
REQ-040 rst_n low at write beat 5 -> outputs at reset values; a new WRITE restarts at addr 0.
REQ-041 PFB_LEVEL_EN, CHANNELS = 1, IMG_H = 4, IMG_W = 4 -> level counts 0..16 during WRITE and returns to 0 after CLEAR.
